// File: rtl/intc_ack_seq_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
package intc_ack_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StVfetch,
    StDeliver
  } IntSeqState_t;

  localparam logic [31:0] VF_BASE_DEF = 32'hFFFF_FFF0;
  localparam int unsigned TO_CYC_DEF  = 16;

  typedef struct packed {
    logic [3:0] lvl;
    logic [7:0] vec;
    logic       ext;
    logic       nmi;
  } IntOffer_t;

  // NMI bypasses the SR.I mask; everything else must beat it strictly.
  function automatic logic is_eligible(logic req, logic nmi, logic [3:0] lvl, logic [3:0] mask);
    return req && (nmi || (lvl > mask));
  endfunction

  function automatic logic [31:0] vf_addr(logic [31:0] base, logic [3:0] lvl);
    return base | {28'b0, lvl};
  endfunction

endpackage

// File: rtl/intc_ack_seq_if.sv
// Signal bundle between the interrupt controller, CPU core, external bus and the sequencer.
interface intc_ack_seq_if;

  logic        CE_R;
  logic        CE_F;
  logic        INT_REQ;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic        INT_EXT;
  logic        INT_NMI;
  logic        VECMD;
  logic [3:0]  CPU_MASK;
  logic        CPU_ACK;
  logic        CPU_REQ;
  logic [3:0]  CPU_LVL;
  logic [7:0]  CPU_VEC;
  logic        VEC_VALID;
  logic        SRC_CLR;
  logic [31:0] EBUS_A;
  logic        EBUS_REQ;
  logic        IVECF_N;
  logic        EBUS_BUSY;
  logic [7:0]  EBUS_DI;
  logic        VF_ERR;

  // Environment side: controller, CPU and external bus.
  modport master (
    output CE_R, CE_F, INT_REQ, INT_LVL, INT_VEC, INT_EXT, INT_NMI, VECMD, CPU_MASK, CPU_ACK,
    output EBUS_BUSY, EBUS_DI,
    input  CPU_REQ, CPU_LVL, CPU_VEC, VEC_VALID, SRC_CLR, EBUS_A, EBUS_REQ, IVECF_N, VF_ERR
  );

  // Sequencer side.
  modport slave (
    input  CE_R, CE_F, INT_REQ, INT_LVL, INT_VEC, INT_EXT, INT_NMI, VECMD, CPU_MASK, CPU_ACK,
    input  EBUS_BUSY, EBUS_DI,
    output CPU_REQ, CPU_LVL, CPU_VEC, VEC_VALID, SRC_CLR, EBUS_A, EBUS_REQ, IVECF_N, VF_ERR
  );

endinterface

// File: rtl/intc_ack_seq.sv
// Interrupt acknowledge sequencer: offers the winning request to the CPU, optionally fetches an
// external vector byte, then delivers the vector with a strobe and clears the source.
module intc_ack_seq
  import intc_ack_seq_pkg::*;
#(
  parameter logic [31:0] VF_BASE = VF_BASE_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF
) (
  input logic           CLK,
  input logic           RST,
  intc_ack_seq_if.slave bus
);

  localparam logic [7:0] ToLast = 8'(TO_CYC - 1);

  IntSeqState_t state_q;
  IntOffer_t    lat_q;
  logic [7:0]   cnt_q;
  logic         vf_done_q;

  logic         cpu_req_q;
  logic [3:0]   cpu_lvl_q;
  logic [7:0]   cpu_vec_q;
  logic         vec_valid_q;
  logic         src_clr_q;
  logic [31:0]  ebus_a_q;
  logic         ebus_req_q;
  logic         ivecf_n_q;
  logic         vf_err_q;

  IntOffer_t    in_offer;
  logic         in_elig;
  logic         lat_elig;
  logic         preempt;
  logic         fetch_sel;
  logic         timeout;

  always_comb begin
    in_offer  = {bus.INT_LVL, bus.INT_VEC, bus.INT_EXT, bus.INT_NMI};
    in_elig   = is_eligible(bus.INT_REQ, bus.INT_NMI, bus.INT_LVL, bus.CPU_MASK);
    lat_elig  = is_eligible(bus.INT_REQ, lat_q.nmi, lat_q.lvl, bus.CPU_MASK);
    // Equal level never preempts; an NMI preempts any non-NMI regardless of level.
    preempt   = in_elig && ((bus.INT_LVL > lat_q.lvl) || (bus.INT_NMI && !lat_q.nmi));
    fetch_sel = lat_q.ext && bus.VECMD;
    timeout   = (cnt_q == ToLast);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      cnt_q       <= '0;
      vf_done_q   <= 1'b0;
      cpu_req_q   <= 1'b0;
      cpu_lvl_q   <= '0;
      cpu_vec_q   <= '0;
      vec_valid_q <= 1'b0;
      src_clr_q   <= 1'b0;
      ebus_a_q    <= '0;
      ebus_req_q  <= 1'b0;
      ivecf_n_q   <= 1'b1;
      vf_err_q    <= 1'b0;
    end else begin
      // Read data is sampled on the falling phase; the rising phase then finishes the cycle.
      if (bus.CE_F && (state_q == StVfetch) && !vf_done_q && !bus.EBUS_BUSY) begin
        cpu_vec_q <= bus.EBUS_DI;
        vf_done_q <= 1'b1;
      end

      if (bus.CE_R) begin
        vec_valid_q <= 1'b0;
        src_clr_q   <= 1'b0;
        vf_err_q    <= 1'b0;

        unique case (state_q)
          StIdle: begin
            if (in_elig) begin
              lat_q     <= in_offer;
              cpu_req_q <= 1'b1;
              cpu_lvl_q <= bus.INT_LVL;
              state_q   <= StOffer;
            end
          end

          StOffer: begin
            if (bus.CPU_ACK) begin
              if (fetch_sel) begin
                ebus_a_q   <= vf_addr(VF_BASE, lat_q.lvl);
                ebus_req_q <= 1'b1;
                ivecf_n_q  <= 1'b0;
                cnt_q      <= '0;
                vf_done_q  <= 1'b0;
                state_q    <= StVfetch;
              end else begin
                cpu_vec_q   <= lat_q.vec;
                cpu_req_q   <= 1'b0;
                vec_valid_q <= 1'b1;
                src_clr_q   <= 1'b1;
                state_q     <= StDeliver;
              end
            end else if (preempt) begin
              lat_q     <= in_offer;
              cpu_lvl_q <= bus.INT_LVL;
            end else if (!lat_elig) begin
              cpu_req_q <= 1'b0;
              state_q   <= StIdle;
            end
          end

          StVfetch: begin
            if (vf_done_q) begin
              ebus_req_q  <= 1'b0;
              ivecf_n_q   <= 1'b1;
              vf_done_q   <= 1'b0;
              cpu_req_q   <= 1'b0;
              vec_valid_q <= 1'b1;
              src_clr_q   <= 1'b1;
              state_q     <= StDeliver;
            end else if (timeout) begin
              // Bus never answered: fall back to the internal vector and flag the error.
              ebus_req_q  <= 1'b0;
              ivecf_n_q   <= 1'b1;
              vf_err_q    <= 1'b1;
              cpu_vec_q   <= lat_q.vec;
              cpu_req_q   <= 1'b0;
              vec_valid_q <= 1'b1;
              src_clr_q   <= 1'b1;
              state_q     <= StDeliver;
            end else if (bus.EBUS_BUSY && (cnt_q != 8'hFF)) begin
              cnt_q <= cnt_q + 8'd1;
            end
          end

          StDeliver: begin
            state_q <= StIdle;
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.CPU_REQ   = cpu_req_q;
  assign bus.CPU_LVL   = cpu_lvl_q;
  assign bus.CPU_VEC   = cpu_vec_q;
  assign bus.VEC_VALID = vec_valid_q;
  assign bus.SRC_CLR   = src_clr_q;
  assign bus.EBUS_A    = ebus_a_q;
  assign bus.EBUS_REQ  = ebus_req_q;
  assign bus.IVECF_N   = ivecf_n_q;
  assign bus.VF_ERR    = vf_err_q;

endmodule

// File: tb/tb_intc_ack_seq.sv
// Self-checking bench for intc_ack_seq: randomized requests against a request-level model.
module tb_intc_ack_seq;

  localparam logic [31:0] VF_BASE_TB = 32'hFFFF_FFF0;
  localparam int          TO_CYC_TB  = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ce_ph = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  intc_ack_seq_if ifc ();

  intc_ack_seq #(
    .VF_BASE(VF_BASE_TB),
    .TO_CYC (TO_CYC_TB)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // Rising and falling phase enables alternate, changing away from the active edge.
  always @(negedge clk) begin
    ce_ph    = ~ce_ph;
    ifc.CE_R = ce_ph;
    ifc.CE_F = ~ce_ph;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step_r();
    do @(posedge clk); while (ifc.CE_R !== 1'b1);
    #1;
  endtask

  task automatic set_req(input logic [3:0] lvl, input logic [7:0] vec, input logic ext,
                         input logic nmi);
    ifc.INT_REQ = 1'b1;
    ifc.INT_LVL = lvl;
    ifc.INT_VEC = vec;
    ifc.INT_EXT = ext;
    ifc.INT_NMI = nmi;
  endtask

  task automatic go_idle();
    ifc.INT_REQ   = 1'b0;
    ifc.INT_NMI   = 1'b0;
    ifc.CPU_ACK   = 1'b0;
    ifc.EBUS_BUSY = 1'b0;
    step_r();
    step_r();
  endtask

  task automatic test_reset();
    logic [17:0] got;
    logic [17:0] exp;
    ifc.INT_REQ = 0; ifc.INT_LVL = 0; ifc.INT_VEC = 0; ifc.INT_EXT = 0; ifc.INT_NMI = 0;
    ifc.VECMD = 0; ifc.CPU_MASK = 0; ifc.CPU_ACK = 0; ifc.EBUS_BUSY = 0; ifc.EBUS_DI = 0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp = {1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    got = {ifc.CPU_REQ, ifc.CPU_LVL, ifc.CPU_VEC, ifc.VEC_VALID, ifc.SRC_CLR, ifc.EBUS_REQ,
           ifc.IVECF_N, ifc.VF_ERR};
    n_chk++; if (got !== exp) begin n_err++;
      $display("FAIL reset_outputs: got %0h want %0h", got, exp); end
    n_chk++; if (ifc.EBUS_A !== 32'h0) begin n_err++;
      $display("FAIL reset_ebus_a: got %0h want %0h", ifc.EBUS_A, 32'h0); end
    #2 rst = 1'b0;
    step_r();
    n_chk++; if (ifc.CPU_REQ !== 1'b0) begin n_err++;
      $display("FAIL reset_idle_req: got %0b want 0", ifc.CPU_REQ); end
  endtask

  task automatic test_internal();
    int m, l;
    logic [7:0] vec;
    logic ext;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin m = 3; l = 5; vec = 8'h44; ext = 1'b0; ifc.VECMD = 1'b0; end
      else begin
        m = $urandom_range(0, 14); l = $urandom_range(m + 1, 15); vec = 8'($urandom);
        ext = 1'($urandom); ifc.VECMD = ext ? 1'b0 : 1'($urandom);
      end
      ifc.CPU_MASK = 4'(m);
      set_req(4'(l), vec, ext, 1'b0);
      step_r();
      n_chk++; if (ifc.CPU_REQ !== 1'b1 || ifc.CPU_LVL !== 4'(l)) begin n_err++;
        $display("FAIL int_offer: got req %0b lvl %0h want req 1 lvl %0h",
                 ifc.CPU_REQ, ifc.CPU_LVL, l); end
      ifc.CPU_ACK = 1'b1;
      step_r();
      ifc.CPU_ACK = 1'b0;
      n_chk++; if (ifc.VEC_VALID !== 1'b1 || ifc.CPU_VEC !== vec) begin n_err++;
        $display("FAIL int_deliver: got valid %0b vec %0h want valid 1 vec %0h",
                 ifc.VEC_VALID, ifc.CPU_VEC, vec); end
      n_chk++; if (ifc.SRC_CLR !== 1'b1 || ifc.CPU_REQ !== 1'b0 || ifc.EBUS_REQ !== 1'b0)
        begin n_err++;
        $display("FAIL int_deliver_ctl: got clr %0b req %0b ebus %0b want 1 0 0",
                 ifc.SRC_CLR, ifc.CPU_REQ, ifc.EBUS_REQ); end
      ifc.INT_REQ = 1'b0;
      step_r();
      n_chk++; if (ifc.VEC_VALID !== 1'b0 || ifc.SRC_CLR !== 1'b0) begin n_err++;
        $display("FAIL int_strobe_len: got valid %0b clr %0b want 0 0",
                 ifc.VEC_VALID, ifc.SRC_CLR); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec;
    ifc.CPU_MASK = 4'h0; ifc.VECMD = 1'b0;
    set_req(4'h3, 8'h13, 1'b0, 1'b0);
    step_r();
    for (int i = 0; i < 3; i++) begin
      ifc.CPU_ACK = 1'b1;
      step_r();
      ifc.CPU_ACK = 1'b0;
      vec = 8'($urandom);
      ifc.INT_VEC = vec;
      n_chk++; if (ifc.CPU_REQ !== 1'b0 || ifc.VEC_VALID !== 1'b1) begin n_err++;
        $display("FAIL b2b_deliver: got req %0b valid %0b want 0 1",
                 ifc.CPU_REQ, ifc.VEC_VALID); end
      step_r();
      n_chk++; if (ifc.CPU_REQ !== 1'b0) begin n_err++;
        $display("FAIL b2b_gap: got req %0b want 0", ifc.CPU_REQ); end
      step_r();
      n_chk++; if (ifc.CPU_REQ !== 1'b1) begin n_err++;
        $display("FAIL b2b_reoffer: got req %0b want 1", ifc.CPU_REQ); end
    end
    go_idle();
  endtask

  task automatic test_preempt();
    int n;
    logic [3:0] lvls [8];
    logic [7:0] vecs [8];
    logic [3:0] win_lvl;
    logic [7:0] win_vec;
    ifc.CPU_MASK = 4'h0; ifc.VECMD = 1'b0;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        n = 3;
        lvls[0] = 4'h4; vecs[0] = 8'h40;
        lvls[1] = 4'h9; vecs[1] = 8'h48;
        lvls[2] = 4'h9; vecs[2] = 8'h99;
      end else begin
        n = $urandom_range(2, 8);
        for (int j = 0; j < n; j++) begin
          lvls[j] = 4'($urandom_range(1, (j == 0) ? 14 : 15));
          vecs[j] = 8'($urandom);
        end
      end
      win_lvl = lvls[0]; win_vec = vecs[0];
      for (int j = 0; j < n; j++) begin
        set_req(lvls[j], vecs[j], 1'b0, 1'b0);
        step_r();
        if (lvls[j] > win_lvl) begin win_lvl = lvls[j]; win_vec = vecs[j]; end
        n_chk++; if (ifc.CPU_REQ !== 1'b1 || ifc.CPU_LVL !== win_lvl) begin n_err++;
          $display("FAIL preempt_lvl: got req %0b lvl %0h want req 1 lvl %0h",
                   ifc.CPU_REQ, ifc.CPU_LVL, win_lvl); end
      end
      // A would-be preempt in the ACK cycle must lose to the ACK.
      set_req(4'hF, 8'hEE, 1'b0, 1'b0);
      ifc.CPU_ACK = 1'b1;
      step_r();
      ifc.CPU_ACK = 1'b0;
      n_chk++; if (ifc.VEC_VALID !== 1'b1 || ifc.CPU_VEC !== win_vec) begin n_err++;
        $display("FAIL preempt_vec: got valid %0b vec %0h want valid 1 vec %0h",
                 ifc.VEC_VALID, ifc.CPU_VEC, win_vec); end
      go_idle();
    end
  endtask

  task automatic test_ext_fetch();
    int nb;
    logic [3:0] lvl;
    logic [7:0] vec, di;
    logic [31:0] exp_a;
    logic busy_ok;
    ifc.CPU_MASK = 4'h0; ifc.VECMD = 1'b1;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin nb = 3; lvl = 4'hB; vec = 8'h2B; di = 8'h71; end
      else begin
        nb = $urandom_range(0, 6); lvl = 4'($urandom_range(1, 15));
        vec = 8'($urandom); di = 8'($urandom);
      end
      exp_a = VF_BASE_TB | {28'b0, lvl};
      set_req(lvl, vec, 1'b1, 1'b0);
      step_r();
      ifc.EBUS_BUSY = (nb > 0);
      ifc.EBUS_DI   = ~di;
      ifc.CPU_ACK   = 1'b1;
      step_r();
      ifc.CPU_ACK = 1'b0;
      n_chk++; if (ifc.EBUS_A !== exp_a || ifc.EBUS_REQ !== 1'b1 || ifc.IVECF_N !== 1'b0)
        begin n_err++;
        $display("FAIL fetch_start: got a %0h req %0b ivecf_n %0b want a %0h req 1 ivecf_n 0",
                 ifc.EBUS_A, ifc.EBUS_REQ, ifc.IVECF_N, exp_a); end
      busy_ok = 1'b1;
      for (int k = 0; k < nb; k++) begin
        step_r();
        if (ifc.IVECF_N !== 1'b0 || ifc.VEC_VALID !== 1'b0 || ifc.CPU_REQ !== 1'b1)
          busy_ok = 1'b0;
      end
      n_chk++; if (busy_ok !== 1'b1) begin n_err++;
        $display("FAIL fetch_busy_hold: got %0b want 1", busy_ok); end
      ifc.EBUS_BUSY = 1'b0;
      ifc.EBUS_DI   = di;
      step_r();
      n_chk++; if (ifc.VEC_VALID !== 1'b1 || ifc.CPU_VEC !== di || ifc.VF_ERR !== 1'b0)
        begin n_err++;
        $display("FAIL fetch_deliver: got valid %0b vec %0h err %0b want valid 1 vec %0h err 0",
                 ifc.VEC_VALID, ifc.CPU_VEC, ifc.VF_ERR, di); end
      n_chk++; if (ifc.IVECF_N !== 1'b1 || ifc.EBUS_REQ !== 1'b0 || ifc.SRC_CLR !== 1'b1)
        begin n_err++;
        $display("FAIL fetch_release: got ivecf_n %0b req %0b clr %0b want 1 0 1",
                 ifc.IVECF_N, ifc.EBUS_REQ, ifc.SRC_CLR); end
      go_idle();
      n_chk++; if (ifc.CPU_VEC !== di) begin n_err++;
        $display("FAIL vec_hold: got %0h want %0h", ifc.CPU_VEC, di); end
    end
    ifc.VECMD = 1'b0;
  endtask

  task automatic test_timeout();
    int first;
    logic [3:0] lvl;
    logic [7:0] vec;
    logic hold_ok;
    ifc.CPU_MASK = 4'h0; ifc.VECMD = 1'b1;
    for (int it = 0; it < 2; it++) begin
      lvl = (it == 0) ? 4'h7 : 4'($urandom_range(1, 15));
      vec = (it == 0) ? 8'h37 : 8'($urandom);
      set_req(lvl, vec, 1'b1, 1'b0);
      step_r();
      ifc.EBUS_BUSY = 1'b1;
      ifc.EBUS_DI   = 8'hA5;
      ifc.CPU_ACK   = 1'b1;
      step_r();
      ifc.CPU_ACK = 1'b0;
      first = 0; hold_ok = 1'b1;
      for (int k = 1; k <= 40 && first == 0; k++) begin
        step_r();
        if (ifc.VF_ERR === 1'b1) first = k;
        else if (ifc.IVECF_N !== 1'b0) hold_ok = 1'b0;
      end
      n_chk++; if (first != TO_CYC_TB || hold_ok !== 1'b1) begin n_err++;
        $display("FAIL timeout_cycle: got %0d hold %0b want %0d hold 1",
                 first, hold_ok, TO_CYC_TB); end
      n_chk++; if (ifc.CPU_VEC !== vec || ifc.VEC_VALID !== 1'b1 || ifc.IVECF_N !== 1'b1)
        begin n_err++;
        $display("FAIL timeout_fallback: got vec %0h valid %0b ivecf_n %0b want %0h 1 1",
                 ifc.CPU_VEC, ifc.VEC_VALID, ifc.IVECF_N, vec); end
      step_r();
      n_chk++; if (ifc.VF_ERR !== 1'b0) begin n_err++;
        $display("FAIL timeout_pulse: got %0b want 0", ifc.VF_ERR); end
      go_idle();
    end
    ifc.VECMD = 1'b0;
  endtask

  task automatic test_withdraw_nmi();
    logic seen;
    ifc.VECMD = 1'b0; ifc.CPU_MASK = 4'h0;
    set_req(4'h6, 8'h66, 1'b0, 1'b0);
    step_r();
    ifc.CPU_MASK = 4'hF;
    step_r();
    seen = ifc.SRC_CLR | ifc.VEC_VALID;
    n_chk++; if (ifc.CPU_REQ !== 1'b0) begin n_err++;
      $display("FAIL withdraw_mask: got req %0b want 0", ifc.CPU_REQ); end
    step_r();
    seen = seen | ifc.SRC_CLR | ifc.VEC_VALID | ifc.CPU_REQ;
    n_chk++; if (seen !== 1'b0) begin n_err++;
      $display("FAIL withdraw_quiet: got %0b want 0", seen); end
    ifc.CPU_MASK = 4'($urandom_range(0, 5));
    step_r();
    ifc.INT_REQ = 1'b0;
    step_r();
    n_chk++; if (ifc.CPU_REQ !== 1'b0 || ifc.SRC_CLR !== 1'b0) begin n_err++;
      $display("FAIL withdraw_req: got req %0b clr %0b want 0 0", ifc.CPU_REQ, ifc.SRC_CLR); end
    step_r();
    ifc.CPU_MASK = 4'hF;
    set_req(4'hF, 8'd11, 1'b0, 1'b1);
    step_r();
    n_chk++; if (ifc.CPU_REQ !== 1'b1 || ifc.CPU_LVL !== 4'hF) begin n_err++;
      $display("FAIL nmi_offer: got req %0b lvl %0h want 1 f", ifc.CPU_REQ, ifc.CPU_LVL); end
    ifc.CPU_ACK = 1'b1;
    step_r();
    ifc.CPU_ACK = 1'b0;
    n_chk++; if (ifc.VEC_VALID !== 1'b1 || ifc.CPU_VEC !== 8'd11) begin n_err++;
      $display("FAIL nmi_deliver: got valid %0b vec %0h want 1 b", ifc.VEC_VALID, ifc.CPU_VEC);
    end
    go_idle();
    // A low-level NMI still displaces an offered maskable request.
    ifc.CPU_MASK = 4'h0;
    set_req(4'h9, 8'h90, 1'b0, 1'b0);
    step_r();
    set_req(4'h3, 8'h33, 1'b0, 1'b1);
    step_r();
    n_chk++; if (ifc.CPU_LVL !== 4'h3) begin n_err++;
      $display("FAIL nmi_preempt_lvl: got %0h want 3", ifc.CPU_LVL); end
    ifc.CPU_ACK = 1'b1;
    step_r();
    ifc.CPU_ACK = 1'b0;
    n_chk++; if (ifc.CPU_VEC !== 8'h33) begin n_err++;
      $display("FAIL nmi_preempt_vec: got %0h want 33", ifc.CPU_VEC); end
    go_idle();
  endtask

  task automatic test_reset_in_fetch();
    logic [17:0] got;
    logic [17:0] exp;
    logic quiet;
    ifc.CPU_MASK = 4'h0; ifc.VECMD = 1'b1;
    set_req(4'hA, 8'h5A, 1'b1, 1'b0);
    step_r();
    ifc.EBUS_BUSY = 1'b1;
    ifc.CPU_ACK   = 1'b1;
    step_r();
    ifc.CPU_ACK = 1'b0;
    step_r();
    #2 rst = 1'b1;
    #1;
    exp = {1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    got = {ifc.CPU_REQ, ifc.CPU_LVL, ifc.CPU_VEC, ifc.VEC_VALID, ifc.SRC_CLR, ifc.EBUS_REQ,
           ifc.IVECF_N, ifc.VF_ERR};
    n_chk++; if (got !== exp || ifc.EBUS_A !== 32'h0) begin n_err++;
      $display("FAIL rst_in_fetch: got %0h a %0h want %0h a 0", got, ifc.EBUS_A, exp); end
    ifc.INT_REQ = 1'b0; ifc.EBUS_BUSY = 1'b0; ifc.EBUS_DI = 8'h77;
    #2 rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step_r();
      if (ifc.VEC_VALID !== 1'b0 || ifc.SRC_CLR !== 1'b0 || ifc.IVECF_N !== 1'b1 ||
          ifc.CPU_REQ !== 1'b0) quiet = 1'b0;
    end
    n_chk++; if (quiet !== 1'b1) begin n_err++;
      $display("FAIL rst_after_quiet: got %0b want 1", quiet); end
    ifc.VECMD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_internal();
    test_back_to_back();
    test_preempt();
    test_ext_fetch();
    test_timeout();
    test_withdraw_nmi();
    test_reset_in_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
